// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: product width helper,
// default multiplier latency and accumulator FSM encoding.
package product_accumulator_pkg;

    localparam int DEFAULT_LATENCY = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_e;

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/product_accumulator_valid_delay_line.sv
// Parameterised-depth shift register used to align issue-time sideband
// bits with a fixed-latency datapath.
module valid_delay_line #(
    parameter int DEPTH = 2,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [DEPTH];

    // shift sideband one stage per clock; reset flushes in-flight entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= {W{1'b0}};
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/product_accumulator.sv
// Sums the multiplier product stream into per-vector dot products and
// presents each result through a valid/ready output register.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int LATENCY   = DEFAULT_LATENCY,
    parameter int MAX_TERMS = 8,
    parameter int ACC_W     = 2*WIDTH + $clog2(MAX_TERMS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    input  logic                         issue_last,
    input  logic [2*WIDTH-1:0]           y,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_data,
    output logic [$clog2(MAX_TERMS):0]   out_count,
    output logic                         err_drop,
    output logic                         err_len,
    input  logic                         clr_err
);

    localparam int PW    = prod_width(WIDTH);
    localparam int CNT_W = $clog2(MAX_TERMS) + 1;

    logic [1:0]       side_s;
    logic [1:0]       dly_s;
    logic             p_valid_s;
    logic             p_last_s;

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_s;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             close_s;
    logic             len_ev_s;

    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             err_drop_q, err_drop_d;
    logic             err_len_q, err_len_d;
    logic             load_s;
    logic             drop_s;

    // a last marker only means something on a valid term
    assign side_s = {issue_valid, issue_valid & issue_last};

    valid_delay_line #(
        .DEPTH (LATENCY),
        .W     (2)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (side_s),
        .q_o   (dly_s)
    );

    assign p_valid_s = dly_s[1];
    assign p_last_s  = dly_s[0];

    // accumulator FSM: running sum/count and vector close decision
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        close_s  = 1'b0;
        len_ev_s = 1'b0;
        sum_s    = ACC_W'(y);
        cnt_nx_s = CNT_W'(1);
        case (state_q)
            ST_EMPTY: begin
                sum_s    = ACC_W'(y);
                cnt_nx_s = CNT_W'(1);
            end
            ST_ACCUM: begin
                sum_s    = acc_q + ACC_W'(y);
                cnt_nx_s = cnt_q + CNT_W'(1);
            end
            default: begin
                sum_s    = ACC_W'(y);
                cnt_nx_s = CNT_W'(1);
            end
        endcase
        if (p_valid_s) begin
            if (p_last_s || (cnt_nx_s == CNT_W'(MAX_TERMS))) begin
                close_s  = 1'b1;
                len_ev_s = ~p_last_s;
                state_d  = ST_EMPTY;
                acc_d    = {ACC_W{1'b0}};
                cnt_d    = {CNT_W{1'b0}};
            end else begin
                state_d = ST_ACCUM;
                acc_d   = sum_s;
                cnt_d   = cnt_nx_s;
            end
        end else begin
            state_d = state_q;
        end
    end

    // a close into a full, stalled register loses the new result
    assign load_s = close_s & (~out_valid_q | out_ready);
    assign drop_s = close_s & out_valid_q & ~out_ready;

    // output register and sticky flags; set events win over clr_err
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        err_drop_d  = err_drop_q;
        err_len_d   = err_len_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sum_s;
            out_count_d = cnt_nx_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (drop_s) begin
            err_drop_d = 1'b1;
        end else if (clr_err) begin
            err_drop_d = 1'b0;
        end else begin
            err_drop_d = err_drop_q;
        end
        if (close_s && len_ev_s) begin
            err_len_d = 1'b1;
        end else if (clr_err) begin
            err_len_d = 1'b0;
        end else begin
            err_len_d = err_len_q;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {ACC_W{1'b0}};
            out_count_q <= {CNT_W{1'b0}};
            err_drop_q  <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            err_drop_q  <= err_drop_d;
            err_len_q   <= err_len_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign err_drop  = err_drop_q;
    assign err_len   = err_len_q;

    logic unused_s;
    assign unused_s = ^PW;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed plus randomized bench for product_accumulator; the bench also plays
// the role of the fixed-latency multiplier feeding y.
module tb_product_accumulator;

    localparam int WIDTH     = 4;
    localparam int LAT       = 2;
    localparam int MAX_TERMS = 8;
    localparam int ACC_W     = 2*WIDTH + $clog2(MAX_TERMS);
    localparam int CNT_W     = $clog2(MAX_TERMS) + 1;
    localparam int PW        = 2*WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue_valid = 1'b0;
    logic             issue_last = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [PW-1:0]    y;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             err_drop;
    logic             err_len;
    logic             clr_err = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    product_accumulator #(
        .WIDTH(WIDTH), .LATENCY(LAT), .MAX_TERMS(MAX_TERMS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_last(issue_last),
        .y(y), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .err_drop(err_drop), .err_len(err_len), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // behavioural multiplier: y is a*b from LAT cycles earlier
    logic [PW-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= PW'(a) * PW'(b);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign y = mpipe[LAT-1];

    // reference model: terms in flight, current vector, expected outputs
    typedef struct { bit valid; bit last; int prod; } term_t;
    term_t hist[$];
    int    vec[$];
    bit    exp_valid;
    int    exp_data, exp_count;
    bit    exp_drop, exp_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("out_data",  32'(out_data),  32'(exp_data));
        check("out_count", 32'(out_count), 32'(exp_count));
        check("err_drop",  32'(err_drop),  32'(exp_drop));
        check("err_len",   32'(err_len),   32'(exp_len));
    endtask

    task automatic model_reset();
        term_t z;
        z.valid = 1'b0; z.last = 1'b0; z.prod = 0;
        hist.delete();
        for (int i = 0; i < LAT; i++) hist.push_back(z);
        vec.delete();
        exp_valid = 1'b0; exp_data = 0; exp_count = 0;
        exp_drop = 1'b0; exp_len = 1'b0;
    endtask

    task automatic cycle(input bit v, input bit l, input int ai, input int bi,
                         input bit rdy, input bit clr);
        term_t nt, t;
        bit closing, lenev;
        int sum, ccount;
        issue_valid = v; issue_last = l;
        a = WIDTH'(ai); b = WIDTH'(bi);
        out_ready = rdy; clr_err = clr;
        nt.valid = v; nt.last = v & l; nt.prod = ai * bi;
        hist.push_back(nt);
        t = hist.pop_front();
        closing = 1'b0; lenev = 1'b0; sum = 0; ccount = 0;
        if (t.valid) begin
            vec.push_back(t.prod);
            if (t.last || vec.size() == MAX_TERMS) begin
                closing = 1'b1;
                foreach (vec[i]) sum += vec[i];
                ccount = vec.size();
                lenev = !t.last;
                vec.delete();
            end
        end
        if (closing && exp_valid && !rdy) exp_drop = 1'b1;
        else if (clr) exp_drop = 1'b0;
        if (closing && lenev) exp_len = 1'b1;
        else if (clr) exp_len = 1'b0;
        if (closing && (!exp_valid || rdy)) begin
            exp_valid = 1'b1; exp_data = sum; exp_count = ccount;
        end else if (exp_valid && rdy) begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 1'b0, 0, 0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        issue_valid = 1'b0; issue_last = 1'b0; clr_err = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: three-term vector, result at last-issue + LAT + 1
        cycle(1, 0, 3, 5, 1, 0);
        cycle(1, 0, 2, 7, 1, 0);
        cycle(1, 1, 15, 15, 1, 0);
        check("t1_valid_early", 32'(out_valid), 32'd0);
        idle(1);
        check("t1_valid_early2", 32'(out_valid), 32'd0);
        idle(1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'd254);
        check("t1_count", 32'(out_count), 32'd3);
        idle(1);
        check("t1_one_cycle", 32'(out_valid), 32'd0);

        // 2: single term
        cycle(1, 1, 15, 15, 1, 0);
        idle(1);
        idle(1);
        check("t2_data", 32'(out_data), 32'd225);
        check("t2_count", 32'(out_count), 32'd1);
        check("t2_flags", 32'({err_drop, err_len}), 32'd0);
        idle(1);

        // 3: stalled consumer drops the second result
        cycle(1, 1, 1, 1, 0, 0);
        cycle(1, 1, 2, 2, 0, 0);
        idle(0);
        idle(0);
        check("t3_data_kept", 32'(out_data), 32'd1);
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_drop", 32'(err_drop), 32'd1);
        idle(1);
        check("t3_valid_fall", 32'(out_valid), 32'd0);
        cycle(0, 0, 0, 0, 1, 1);
        check("t3_clr", 32'(err_drop), 32'd0);

        // 4: back-to-back vectors
        cycle(1, 1, 4, 4, 1, 0);
        cycle(1, 1, 5, 5, 1, 0);
        idle(1);
        check("t4_first", 32'(out_data), 32'd16);
        idle(1);
        check("t4_second", 32'(out_data), 32'd25);
        check("t4_second_valid", 32'(out_valid), 32'd1);
        check("t4_nodrop", 32'(err_drop), 32'd0);
        idle(1);

        // 5: forced close at MAX_TERMS
        for (int i = 0; i < 9; i++) cycle(1, 0, 1, 1, 1, 0);
        idle(1);
        check("t5_data", 32'(out_data), 32'd8);
        check("t5_count", 32'(out_count), 32'd8);
        check("t5_len", 32'(err_len), 32'd1);
        cycle(1, 1, 1, 1, 1, 0);
        idle(1);
        idle(1);
        check("t5_next_data", 32'(out_data), 32'd2);
        check("t5_next_count", 32'(out_count), 32'd2);
        cycle(0, 0, 0, 0, 1, 1);

        // 6: reset with terms in flight
        cycle(1, 0, 3, 3, 1, 0);
        cycle(1, 1, 2, 2, 1, 0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("t6_no_result", 32'(out_valid), 32'd0);
        end
        cycle(1, 1, 6, 7, 1, 0);
        idle(1);
        idle(1);
        check("t6_data", 32'(out_data), 32'd42);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < LAT + 2; i++) idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the pipelined array multiplier: sums a stream of products y into per-vector dot products.
- Aligns an issue-time valid/last sideband with the multiplier's fixed pipeline latency.
- Presents each completed sum through a valid/ready output register.
- The multiplier itself has no handshake; this block provides the only flow-control and error reporting on the product path.

Parameters:
- WIDTH, 4, operand width of the multiplier; product width is 2*WIDTH.
- LATENCY, 2, multiplier pipeline depth in cycles; y at cycle k is the product of a,b presented at cycle k-LATENCY.
- MAX_TERMS, 8, maximum products per vector before a forced close.
- ACC_W, 2*WIDTH+$clog2(MAX_TERMS), accumulator and result width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  a,b presented to the multiplier this cycle form a term.
- issue_last  in  1  qualifies issue_valid; marks the final term of a vector.
- y  in  2*WIDTH  multiplier product output.
- out_valid  out  1  result register full.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  ACC_W  completed dot product.
- out_count  out  $clog2(MAX_TERMS)+1  number of terms in out_data.
- err_drop  out  1  sticky: a completed result was lost.
- err_len  out  1  sticky: a vector was force-closed at MAX_TERMS.
- clr_err  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset: all registers, including the delay line, clear to 0 (out_valid, out_data, out_count, err_drop, err_len). In-flight terms are discarded, and the accumulator returns to EMPTY.
- Delay line:
  - LATENCY-stage shift register carries {issue_valid, issue_last}.
  - Stage output gives p_valid/p_last, aligned with y.
  - issue_last without issue_valid is ignored.
- Accumulator FSM, states EMPTY and ACCUM:
  - EMPTY, p_valid: acc=y (zero-extended), cnt=1; go to ACCUM, or close if p_last.
  - ACCUM, p_valid: acc=acc+y, cnt=cnt+1; close if p_last or cnt+1==MAX_TERMS.
  - Close on MAX_TERMS without p_last also sets err_len. The next term starts a new vector.
  - No p_valid: hold state.
- Close:
  - Final sum and count load into the output register; FSM goes to EMPTY the same edge.
  - Next term can arrive the following cycle (back-to-back vectors, no bubble).
- Output register:
  - out_valid falls on out_valid&&out_ready unless a close occurs the same cycle.
  - Close with register empty, or full and out_ready=1: load, out_valid=1.
  - Close with register full and out_ready=0: new result discarded, err_drop set, old result retained unchanged.
- Latency:
  - A term issued with issue_last in cycle t gives out_valid=1 in cycle t+LATENCY+1.
  - Products are never stalled; the upstream multiplier cannot be back-pressured.
- Arithmetic:
  - Unsigned; ACC_W is sized so MAX_TERMS products of (2^WIDTH-1)^2 never overflow.
  - No saturation logic.
- Flags: clr_err clears both flags; a set event in the same cycle wins over clr_err.
- Reset asserted mid-vector: partial sum lost, no result produced, no flag set.

Decomposition:
- Shared package holds:
  - product width function 2*WIDTH;
  - default LATENCY=2, matching the current multiplier;
  - FSM state encoding EMPTY/ACCUM.
- One sub-module: valid_delay_line, a parameterised-depth, parameterised-width shift register with async active-low reset. It is reusable for other pipelined datapath sideband alignment.

Test Plan:
1. WIDTH=4: terms 3*5, 2*7, 15*15, last on third, out_ready=1 -> out_data=254, out_count=3; out_valid high exactly one cycle, at issue cycle of last +3.
2. Single term 15*15 with issue_last -> out_data=225, out_count=1; FSM back to EMPTY; no flags.
3. out_ready=0; vector {1*1} then vector {2*2} -> out_data stays 1, err_drop=1; then out_ready=1 -> out_valid falls; pulse clr_err -> err_drop=0.
4. Two back-to-back vectors {4*4} and {5*5}, each last, out_ready=1 every cycle -> results 16 then 25 on consecutive cycles; err_drop=0.
5. MAX_TERMS=8: nine 1*1 terms, no last -> result 8 with count 8 and err_len=1; ninth term starts a new vector with acc=1.
6. rst_n low for one cycle with two terms in the delay line -> out_valid=0 and no result from the aborted terms; following vector {6*7} last -> out_data=42.
